cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have parameter HAS_FPU, default 1: 1 enables f32.const/f64.const; 0 makes them trap NO_FPU.
REQ-002 SHALL have parameter USE_64B, default 1: 1 enables 64-bit opcodes; 0 makes them trap NO_64B.
REQ-003 SHALL have parameter MEM_DEPTH, default 4: program byte address width is MEM_DEPTH+1.
REQ-004 SHALL use one clock and a synchronous active-low reset: ports clk, then reset.
REQ-005 SHALL have ports:
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-low.
- result  out  64: top-of-stack value; i32/f32 zero-extended.
- result_type  out  2: type of the top-of-stack value, encoded i32=0, i64=1, f32=2, f64=3.
- result_empty  out  1: 1 when the operand stack is empty.
- trap  out  4: status, encoded NONE=0, ENDED=1, UNREACHABLE=2, TYPE_MISMATCH=3, STACK_UNDERFLOW=4, STACK_OVERFLOW=5, UNKNOWN_OPCODE=6, NO_64B=7, MEM_ERROR=8, NO_FPU=9.
- mem_addr  out  MEM_DEPTH+1: byte address of the fetch.
- mem_extra  out  4: number of additional bytes requested; the CPU always drives 15.
- mem_data  in  128: fetched bytes; byte at mem_addr in [7:0], byte at mem_addr+k in [8k+7:8k].
- mem_error  in  1: the fetch was out of ROM bounds.

Function
REQ-006 Memory contract: the ROM registers its read, so mem_data/mem_error are valid the cycle after mem_addr/mem_extra are presented.
REQ-007 The CPU SHALL use a two-state machine, FETCH -> DECODE -> FETCH; each instruction takes exactly 2 cycles.
REQ-008 FETCH SHALL drive mem_addr = pc and mem_extra = 15.
REQ-009 DECODE SHALL execute the opcode in mem_data[7:0] and advance pc by the instruction length.
REQ-010 If mem_error = 1 in DECODE, the CPU SHALL set trap = MEM_ERROR; this takes priority over opcode decode.
REQ-011 The operand stack SHALL be 8 entries of 64-bit value plus 2-bit type; the outputs SHALL reflect the top entry combinationally.
REQ-012 The CPU SHALL support exactly these opcodes:
- 0x00 unreachable -> trap UNREACHABLE.
- 0x01 nop.
- 0x0B end -> trap ENDED.
- 0x1A drop.
- 0x41 i32.const: signed LEB128, at most 5 bytes.
- 0x42 i64.const: signed LEB128, at most 10 bytes.
- 0x43 f32.const: 4 raw bytes.
- 0x44 f64.const: 8 raw bytes.
- 0x6A i32.add: modulo 2^32.
- 0x7C i64.add: modulo 2^64.
- 0xA7 i32.wrap_i64: low 32 bits, type i32.
- 0xAC i64.extend_i32_s.
- 0xAD i64.extend_i32_u.
REQ-013 LEB128 decoding SHALL consume bytes until bit7 = 0 or the maximum length is reached, then sign-extend from bit6 of the final byte; the result is truncated to the type width.
REQ-014 Any other opcode SHALL set trap = UNKNOWN_OPCODE.
REQ-015 Opcodes 0x42, 0x44, 0x7C, 0xA7, 0xAC and 0xAD SHALL trap NO_64B when USE_64B = 0.
REQ-016 Opcodes 0x43 and 0x44 SHALL trap NO_FPU when HAS_FPU = 0; if both NO_64B and NO_FPU apply, NO_64B SHALL win.
REQ-017 An operand with the wrong type SHALL set trap = TYPE_MISMATCH.
REQ-018 Popping an empty stack SHALL set trap = STACK_UNDERFLOW; pushing onto a full stack (8 entries) SHALL set trap = STACK_OVERFLOW.
REQ-019 A trapping instruction SHALL leave the stack unchanged.
REQ-020 trap SHALL be sticky: once it is non-NONE the CPU halts (no pc or stack change, mem_addr frozen) until reset.
REQ-021 end SHALL leave the stack intact so the result stays visible after ENDED.
REQ-022 pc SHALL wrap modulo 2^(MEM_DEPTH+1).

Reset
REQ-023 While reset = 0 at a clk edge, the CPU SHALL set pc = 0, state = FETCH, stack empty and trap = NONE.
REQ-024 The reset values of the outputs SHALL be result = 0, result_type = 0, result_empty = 1, mem_extra = 15, mem_addr = 0.
REQ-025 A reset asserted mid-instruction SHALL abort the instruction with no stack change; execution restarts at pc 0 on the first edge with reset = 1.

Verification
REQ-026 ROM 42 2A A7 0B, USE_64B = 1, reset released -> within 11 cycles result = 42, result_type = 0, result_empty = 0, trap = ENDED.
REQ-027 Same ROM, USE_64B = 0 -> within 6 cycles trap = NO_64B, result_empty = 1.
REQ-028 ROM 41 7F 41 01 6A 0B -> result = 0 (-1 + 1), result_type = i32, trap = ENDED.
REQ-029 ROM A7 0B -> trap = STACK_UNDERFLOW, result_empty = 1.
REQ-030 ROM 41 05 A7 -> trap = TYPE_MISMATCH with result = 5 still on the stack; ROM FF -> trap = UNKNOWN_OPCODE.
REQ-031 ROM 42 2A A7 0B with reset pulsed low after the 42 2A instruction -> execution restarts at pc 0 and ends with result 42, trap = ENDED.

Source files
------------

// File: rtl/cpu.sv
// Small WebAssembly-subset stack CPU: two-cycle FETCH/DECODE loop over a registered ROM,
// 8-entry typed operand stack, sticky trap status.
module cpu #(
   parameter bit          HAS_FPU   = 1'b1,
   parameter bit          USE_64B   = 1'b1,
   parameter int unsigned MEM_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [63:0]          result,
   output logic [1:0]           result_type,
   output logic                 result_empty,
   output logic [3:0]           trap,
   output logic [MEM_DEPTH:0]   mem_addr,
   output logic [3:0]           mem_extra,
   input  logic [127:0]         mem_data,
   input  logic                 mem_error
);
   localparam int unsigned AW    = MEM_DEPTH + 1;
   localparam int unsigned DEPTH = 8;

   localparam logic [1:0] T_I32 = 2'd0;
   localparam logic [1:0] T_I64 = 2'd1;
   localparam logic [1:0] T_F32 = 2'd2;
   localparam logic [1:0] T_F64 = 2'd3;

   localparam logic [3:0] TR_NONE      = 4'd0;
   localparam logic [3:0] TR_ENDED     = 4'd1;
   localparam logic [3:0] TR_UNREACH   = 4'd2;
   localparam logic [3:0] TR_TYPE      = 4'd3;
   localparam logic [3:0] TR_UNDERFLOW = 4'd4;
   localparam logic [3:0] TR_OVERFLOW  = 4'd5;
   localparam logic [3:0] TR_UNKNOWN   = 4'd6;
   localparam logic [3:0] TR_NO_64B    = 4'd7;
   localparam logic [3:0] TR_MEM       = 4'd8;
   localparam logic [3:0] TR_NO_FPU    = 4'd9;

   typedef enum logic {FETCH, DECODE} state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [3:0]    sp;
   logic [3:0]    trap_q;
   logic [63:0]   stk_val [DEPTH];
   logic [1:0]    stk_typ [DEPTH];

   logic [7:0]    opcode;
   logic [79:0]   imm;
   logic [67:0]   leb32, leb64;
   logic [63:0]   top_val, sec_val, pval;
   logic [1:0]    top_typ, sec_typ, ptyp, exp_typ;
   logic [3:0]    t_c, len;
   logic [1:0]    pops;
   logic          push, chk, need64, needfpu;
   logic          unused_mem;

   // Signed LEB128: returns {length, value}, sign-extended from bit6 of the last byte taken.
   function automatic logic [67:0] leb_decode(input logic [79:0] b, input int maxlen);
      logic [63:0] acc;
      logic [3:0]  n;
      logic        done;
      acc  = '0;
      n    = '0;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!done && i < maxlen) begin
            acc = acc | (64'(b[8*i +: 7]) << (7*i));
            n   = 4'(i + 1);
            if (!b[8*i+7] || i == maxlen - 1) begin
               done = 1'b1;
               if (b[8*i+6]) acc = acc | ({64{1'b1}} << (7*(i+1)));
            end
         end
      end
      return {n, acc};
   endfunction

   assign opcode     = mem_data[7:0];
   assign imm        = mem_data[87:8];
   assign leb32      = leb_decode(imm, 5);
   assign leb64      = leb_decode(imm, 10);
   assign unused_mem = ^mem_data[127:88];

   assign top_val = stk_val[3'(sp - 4'd1)];
   assign top_typ = stk_typ[3'(sp - 4'd1)];
   assign sec_val = stk_val[3'(sp - 4'd2)];
   assign sec_typ = stk_typ[3'(sp - 4'd2)];

   // Decode and trap resolution for the instruction presented in DECODE.
   always_comb begin
      t_c     = TR_NONE;
      len     = 4'd1;
      pops    = 2'd0;
      push    = 1'b0;
      pval    = '0;
      ptyp    = T_I32;
      chk     = 1'b0;
      exp_typ = T_I32;
      need64  = 1'b0;
      needfpu = 1'b0;
      case (opcode)
         8'h00: t_c = TR_UNREACH;
         8'h01: ;
         8'h0B: t_c = TR_ENDED;
         8'h1A: pops = 2'd1;
         8'h41: begin
            len = 4'(leb32[67:64] + 4'd1); push = 1'b1;
            pval = {32'd0, leb32[31:0]};   ptyp = T_I32;
         end
         8'h42: begin
            need64 = 1'b1; len = 4'(leb64[67:64] + 4'd1); push = 1'b1;
            pval = leb64[63:0];            ptyp = T_I64;
         end
         8'h43: begin
            needfpu = 1'b1; len = 4'd5; push = 1'b1;
            pval = {32'd0, mem_data[39:8]}; ptyp = T_F32;
         end
         8'h44: begin
            need64 = 1'b1; needfpu = 1'b1; len = 4'd9; push = 1'b1;
            pval = mem_data[71:8];          ptyp = T_F64;
         end
         8'h6A: begin
            pops = 2'd2; chk = 1'b1; exp_typ = T_I32; push = 1'b1;
            pval = {32'd0, 32'(top_val[31:0] + sec_val[31:0])}; ptyp = T_I32;
         end
         8'h7C: begin
            need64 = 1'b1; pops = 2'd2; chk = 1'b1; exp_typ = T_I64; push = 1'b1;
            pval = top_val + sec_val; ptyp = T_I64;
         end
         8'hA7: begin
            need64 = 1'b1; pops = 2'd1; chk = 1'b1; exp_typ = T_I64; push = 1'b1;
            pval = {32'd0, top_val[31:0]}; ptyp = T_I32;
         end
         8'hAC: begin
            need64 = 1'b1; pops = 2'd1; chk = 1'b1; exp_typ = T_I32; push = 1'b1;
            pval = {{32{top_val[31]}}, top_val[31:0]}; ptyp = T_I64;
         end
         8'hAD: begin
            need64 = 1'b1; pops = 2'd1; chk = 1'b1; exp_typ = T_I32; push = 1'b1;
            pval = {32'd0, top_val[31:0]}; ptyp = T_I64;
         end
         default: t_c = TR_UNKNOWN;
      endcase

      if (mem_error)                 t_c = TR_MEM;
      else if (need64 && !USE_64B)   t_c = TR_NO_64B;
      else if (needfpu && !HAS_FPU)  t_c = TR_NO_FPU;
      else if (t_c == TR_NONE) begin
         if (4'(pops) > sp)
            t_c = TR_UNDERFLOW;
         else if (chk && (top_typ != exp_typ || (pops == 2'd2 && sec_typ != exp_typ)))
            t_c = TR_TYPE;
         else if (push && (sp - 4'(pops)) == 4'(DEPTH))
            t_c = TR_OVERFLOW;
      end
   end

   // State, pc, stack and trap; stack entries need no reset since sp gates their visibility.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= FETCH;
         pc     <= '0;
         sp     <= '0;
         trap_q <= TR_NONE;
      end else begin
         case (state)
            FETCH: if (trap_q == TR_NONE) state <= DECODE;
            DECODE: begin
               state <= FETCH;
               if (t_c != TR_NONE) begin
                  trap_q <= t_c;
               end else begin
                  pc <= pc + AW'(len);
                  sp <= sp - 4'(pops) + 4'(push);
                  if (push) begin
                     stk_val[3'(sp - 4'(pops))] <= pval;
                     stk_typ[3'(sp - 4'(pops))] <= ptyp;
                  end
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign result       = (sp == 4'd0) ? 64'd0 : top_val;
   assign result_type  = (sp == 4'd0) ? T_I32 : top_typ;
   assign result_empty = (sp == 4'd0);
   assign trap         = trap_q;
   assign mem_addr     = pc;
   assign mem_extra    = 4'd15;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: two instances (full-featured and no-64b/no-fpu) share one
// registered-read ROM image.
module tb_cpu;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [63:0]  res_a, res_b;
   logic [1:0]   rt_a, rt_b;
   logic         re_a, re_b;
   logic [3:0]   tr_a, tr_b;
   logic [4:0]   ma_a, ma_b;
   logic [3:0]   mx_a, mx_b;
   logic [127:0] md_a, md_b;
   logic         me_a, me_b;

   cpu #(.HAS_FPU(1'b1), .USE_64B(1'b1), .MEM_DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .result(res_a), .result_type(rt_a), .result_empty(re_a),
      .trap(tr_a), .mem_addr(ma_a), .mem_extra(mx_a), .mem_data(md_a), .mem_error(me_a));

   cpu #(.HAS_FPU(1'b0), .USE_64B(1'b0), .MEM_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .result(res_b), .result_type(rt_b), .result_empty(re_b),
      .trap(tr_b), .mem_addr(ma_b), .mem_extra(mx_b), .mem_data(md_b), .mem_error(me_b));

   logic [7:0] rom [32];
   int         rom_len;
   int         vectors = 0;
   int         errors  = 0;

   // ROM with one cycle of read latency, wrapping at 32 bytes
   always @(posedge clk) begin
      for (int k = 0; k < 16; k++) begin
         md_a[8*k +: 8] <= rom[5'(int'(ma_a) + k)];
         md_b[8*k +: 8] <= rom[5'(int'(ma_b) + k)];
      end
      me_a <= int'(ma_a) >= rom_len;
      me_b <= int'(ma_b) >= rom_len;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Program bytes are right-justified in p: first byte is p[8*n-1 -: 8].
   task automatic load(input logic [255:0] p, input int n);
      for (int i = 0; i < 32; i++) rom[i] = 8'h00;
      for (int i = 0; i < n; i++) rom[i] = p[8*(n-1-i) +: 8];
      rom_len = n;
   endtask

   task automatic restart();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      rom_len = 0;
      for (int i = 0; i < 32; i++) rom[i] = 8'h00;

      // Reset values
      tick(); tick();
      chk("rst_result", res_a, 64'd0);
      chk("rst_type",   64'(rt_a), 64'd0);
      chk("rst_empty",  64'(re_a), 64'd1);
      chk("rst_extra",  64'(mx_a), 64'd15);
      chk("rst_addr",   64'(ma_a), 64'd0);
      chk("rst_trap",   64'(tr_a), 64'd0);

      // i64.const 42; i32.wrap_i64; end
      load(256'({8'h42, 8'h2A, 8'hA7, 8'h0B}), 4);
      restart(); run(11);
      chk("wrap_result", res_a, 64'd42);
      chk("wrap_type",   64'(rt_a), 64'd0);
      chk("wrap_empty",  64'(re_a), 64'd0);
      chk("wrap_trap",   64'(tr_a), 64'd1);
      chk("b_no64_trap", 64'(tr_b), 64'd7);
      chk("b_no64_empty", 64'(re_b), 64'd1);
      run(4);
      chk("sticky_addr_a", 64'(ma_a), 64'd3);
      chk("sticky_addr_b", 64'(ma_b), 64'd0);

      // -1 + 1 in i32
      load(256'({8'h41, 8'h7F, 8'h41, 8'h01, 8'h6A, 8'h0B}), 6);
      restart(); run(14);
      chk("add32_result", res_a, 64'd0);
      chk("add32_type",   64'(rt_a), 64'd0);
      chk("add32_trap",   64'(tr_a), 64'd1);

      // Underflow
      load(256'({8'hA7, 8'h0B}), 2);
      restart(); run(6);
      chk("uflow_trap",  64'(tr_a), 64'd4);
      chk("uflow_empty", 64'(re_a), 64'd1);

      // Type mismatch keeps the operand
      load(256'({8'h41, 8'h05, 8'hA7}), 3);
      restart(); run(8);
      chk("tmis_trap",   64'(tr_a), 64'd3);
      chk("tmis_result", res_a, 64'd5);
      chk("tmis_type",   64'(rt_a), 64'd0);

      // Unknown opcode
      load(256'({8'hFF}), 1);
      restart(); run(4);
      chk("unk_trap", 64'(tr_a), 64'd6);

      // Unreachable
      load(256'({8'h00, 8'h0B}), 2);
      restart(); run(4);
      chk("unreach_trap", 64'(tr_a), 64'd2);

      // Ninth push overflows and leaves the eight entries untouched
      load(256'({{8{16'h4101}}, 16'h4102}), 18);
      restart(); run(24);
      chk("oflow_trap",   64'(tr_a), 64'd5);
      chk("oflow_result", res_a, 64'd1);

      // i32.const stops at 5 bytes even with bit7 set
      load(256'({8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0B}), 7);
      restart(); run(8);
      chk("leb5_trap",   64'(tr_a), 64'd1);
      chk("leb5_result", res_a, 64'd0);
      chk("leb5_empty",  64'(re_a), 64'd0);

      // i64.const -1 using the full 10 bytes
      load(256'({8'h42, {9{8'hFF}}, 8'h7F, 8'h0B}), 12);
      restart(); run(8);
      chk("leb10_result", res_a, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("leb10_type",   64'(rt_a), 64'd1);
      chk("leb10_trap",   64'(tr_a), 64'd1);

      // f32.const 1.0
      load(256'({8'h43, 8'h00, 8'h00, 8'h80, 8'h3F, 8'h0B}), 6);
      restart(); run(8);
      chk("f32_result", res_a, 64'h0000_0000_3F80_0000);
      chk("f32_type",   64'(rt_a), 64'd2);
      chk("b_nofpu",    64'(tr_b), 64'd9);

      // f64.const raw bytes; NO_64B outranks NO_FPU
      load(256'({8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h0B}), 10);
      restart(); run(8);
      chk("f64_result", res_a, 64'h8877_6655_4433_2211);
      chk("f64_type",   64'(rt_a), 64'd3);
      chk("b_f64_trap", 64'(tr_b), 64'd7);

      // sext(-1) + zext(-1) in i64
      load(256'({8'h41, 8'h7F, 8'hAC, 8'h41, 8'h7F, 8'hAD, 8'h7C, 8'h0B}), 8);
      restart(); run(16);
      chk("add64_result", res_a, 64'h0000_0000_FFFF_FFFE);
      chk("add64_type",   64'(rt_a), 64'd1);
      chk("add64_trap",   64'(tr_a), 64'd1);
      chk("b_ext_trap",   64'(tr_b), 64'd7);
      chk("b_ext_result", res_b, 64'h0000_0000_FFFF_FFFF);

      // drop, then fetch past the ROM end
      load(256'({8'h41, 8'h03, 8'h1A}), 3);
      restart(); run(10);
      chk("mem_trap",  64'(tr_a), 64'd8);
      chk("mem_empty", 64'(re_a), 64'd1);

      // Reset pulsed after the first instruction, mid-way through the second
      load(256'({8'h42, 8'h2A, 8'hA7, 8'h0B}), 4);
      restart(); run(2);
      chk("mid_pre_result", res_a, 64'd42);
      chk("mid_pre_type",   64'(rt_a), 64'd1);
      run(1);
      reset = 1'b0;
      tick();
      chk("mid_rst_empty", 64'(re_a), 64'd1);
      chk("mid_rst_addr",  64'(ma_a), 64'd0);
      reset = 1'b1;
      run(11);
      chk("mid_result", res_a, 64'd42);
      chk("mid_type",   64'(rt_a), 64'd0);
      chk("mid_trap",   64'(tr_a), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
